// File: rtl/playback_scheduler.sv
// playback_scheduler: walks one song of the note ROM, times each note in ticks and drives the tone generator.
// Optional macro TEMPO_CTRL_EN adds a tempo[1:0] input; the tick period becomes TICK_DIV >> tempo.
//
// state  | meaning
// IDLE   | waiting for an accepted play
// FETCH  | rom_addr presented, registered ROM read in flight
// LOAD   | rom_data captured; dur == 0 is the end marker
// PLAY   | note sounding for dur ticks
// GAP    | silence between notes for GAP_TICKS ticks
// PAUSED | prescaler/tick counter frozen, outputs silent
module playback_scheduler #(
    parameter int NUM_SONGS = 2,
    parameter int IDX_W     = 6,
    parameter int TICK_DIV  = 100000,
    parameter int GAP_TICKS = 20,
    parameter int DUR_W     = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 play,
    input  logic                 pause,
    input  logic                 stop,
    input  logic                 loop_en,
    input  logic [3:0]           song_sel,
`ifdef TEMPO_CTRL_EN
    input  logic [1:0]           tempo,
`endif
    output logic [4+IDX_W-1:0]   rom_addr,
    input  logic [4+DUR_W-1:0]   rom_data,
    output logic [3:0]           note_out,
    output logic                 note_valid,
    output logic                 busy,
    output logic                 song_done,
    output logic [3:0]           current_song
);

    localparam int PRESC_W = $clog2(TICK_DIV + 1);
    localparam int GAP_W   = $clog2(GAP_TICKS + 1);
    localparam int CNT_W   = (DUR_W > GAP_W) ? DUR_W : GAP_W;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0]   GAP_LOAD   = CNT_W'(GAP_TICKS);
    localparam logic [4:0]         SONG_LIMIT = 5'(NUM_SONGS);

    typedef enum logic [2:0] {IDLE, FETCH, LOAD, PLAY, GAP, PAUSED} state_t;

    state_t             state_q, state_d;
    logic               resume_gap_q, resume_gap_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [3:0]         song_q, song_d;
    logic [3:0]         note_q, note_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               done_q, done_d;
    logic [PRESC_W-1:0] presc_last;
    logic               presc_restart;
    logic               tick;
    logic               last_tick;
    logic               end_hit;
    logic               song_ok;

    assign tick      = (presc_q == presc_last);
    assign last_tick = tick && (cnt_q == CNT_W'(1));
    assign song_ok   = ({1'b0, song_sel} < SONG_LIMIT);

`ifdef TEMPO_CTRL_EN
    logic [PRESC_W-1:0] last_q, last_d, period;

    // Tempo is only sampled when the prescaler restarts, so a tick in progress is never cut short.
    always_comb begin
        period = PRESC_W'(TICK_DIV >> tempo);
        last_d = last_q;
        if (presc_restart) begin
            last_d = (period == '0) ? '0 : period - PRESC_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= PRESC_LAST;
        end else begin
            last_q <= last_d;
        end
    end

    assign presc_last = last_q;
`else
    assign presc_last = PRESC_LAST;
`endif

    always_comb begin
        state_d       = state_q;
        resume_gap_d  = resume_gap_q;
        idx_d         = idx_q;
        song_d        = song_q;
        note_d        = note_q;
        presc_d       = presc_q;
        cnt_d         = cnt_q;
        done_d        = 1'b0;
        presc_restart = 1'b0;
        end_hit       = 1'b0;

        case (state_q)
            IDLE: begin
                if (play && !pause && !stop && song_ok) begin
                    song_d  = song_sel;
                    idx_d   = '0;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                state_d = stop ? IDLE : LOAD;
            end
            LOAD: begin
                if (stop) begin
                    state_d = IDLE;
                end else begin
                    note_d = rom_data[DUR_W +: 4];
                    if (rom_data[DUR_W-1:0] == '0) begin
                        end_hit = 1'b1;
                    end else begin
                        cnt_d         = CNT_W'(rom_data[DUR_W-1:0]);
                        presc_d       = '0;
                        presc_restart = 1'b1;
                        state_d       = PLAY;
                    end
                end
            end
            PLAY, GAP: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (pause || !last_tick) begin
                    // The pause cycle still counts as elapsed time, except on the terminal tick,
                    // which is held so the note/gap is never lost across the pause.
                    if (!last_tick) begin
                        if (tick) begin
                            presc_d       = '0;
                            cnt_d         = cnt_q - CNT_W'(1);
                            presc_restart = 1'b1;
                        end else begin
                            presc_d = presc_q + PRESC_W'(1);
                        end
                    end
                    if (pause) begin
                        resume_gap_d = (state_q == GAP);
                        state_d      = PAUSED;
                    end
                end else if (state_q == GAP) begin
                    state_d = FETCH;
                end else if (idx_q == '1) begin
                    end_hit = 1'b1;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                    if (GAP_TICKS > 0) begin
                        cnt_d         = GAP_LOAD;
                        presc_d       = '0;
                        presc_restart = 1'b1;
                        state_d       = GAP;
                    end else begin
                        state_d = FETCH;
                    end
                end
            end
            PAUSED: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (play && !pause) begin
                    state_d = resume_gap_q ? GAP : PLAY;
                end
            end
            default: state_d = IDLE;
        endcase

        if (end_hit) begin
            if (loop_en) begin
                idx_d   = '0;
                state_d = FETCH;
            end else begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            resume_gap_q <= 1'b0;
            idx_q        <= '0;
            song_q       <= '0;
            note_q       <= '0;
            presc_q      <= '0;
            cnt_q        <= '0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            resume_gap_q <= resume_gap_d;
            idx_q        <= idx_d;
            song_q       <= song_d;
            note_q       <= note_d;
            presc_q      <= presc_d;
            cnt_q        <= cnt_d;
            done_q       <= done_d;
        end
    end

    assign rom_addr     = {song_q, idx_q};
    assign note_out     = (state_q == PLAY) ? note_q : 4'd0;
    assign note_valid   = (state_q == PLAY) && (note_q != 4'd0);
    assign busy         = (state_q != IDLE);
    assign song_done    = done_q;
    assign current_song = song_q;

endmodule

// File: tb/tb_playback_scheduler.sv
// Bench for playback_scheduler: run-length vector table for transport scenarios plus
// hand-written sequences for the 64-entry wrap and mid-note reset.
module tb_playback_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        play, pause, stop, loop_en;
    logic [3:0]  song_sel;
    logic [9:0]  rom_addr;
    logic [11:0] rom_data;
    logic [3:0]  note_out;
    logic        note_valid, busy, song_done;
    logic [3:0]  current_song;

    logic [11:0] rom [0:1023];

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    playback_scheduler #(
        .NUM_SONGS(2), .IDX_W(6), .TICK_DIV(4), .GAP_TICKS(2), .DUR_W(8)
    ) dut (
        .clk(clk), .reset(reset), .play(play), .pause(pause), .stop(stop),
        .loop_en(loop_en), .song_sel(song_sel),
`ifdef TEMPO_CTRL_EN
        .tempo(2'b00),
`endif
        .rom_addr(rom_addr), .rom_data(rom_data), .note_out(note_out),
        .note_valid(note_valid), .busy(busy), .song_done(song_done),
        .current_song(current_song)
    );

    always @(posedge clk) rom_data <= rom[rom_addr];

    typedef struct {
        bit         play, pause, stop, loop_en;
        logic [3:0] sel;
        int         n;
        logic [3:0] note;
        bit         valid, busy, done;
        logic [3:0] song;
        bit         chk_addr;
        logic [9:0] addr;
    } vec_t;

    vec_t vq[$];

    task automatic add(bit p, bit pa, bit s, bit l, logic [3:0] sel, int n,
                       logic [3:0] note, bit v, bit b, bit d, logic [3:0] song,
                       bit ca, logic [9:0] addr);
        vec_t t;
        t.play = p; t.pause = pa; t.stop = s; t.loop_en = l; t.sel = sel; t.n = n;
        t.note = note; t.valid = v; t.busy = b; t.done = d; t.song = song;
        t.chk_addr = ca; t.addr = addr;
        vq.push_back(t);
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total_cnt++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else pass_cnt++;
    endtask

    initial begin
        int done_at, valid_cnt;
        bit saw_last;

        for (int i = 0; i < 1024; i++) rom[i] = 12'h000;
        for (int i = 0; i < 64; i++) rom[i] = {4'((i % 15) + 1), 8'd1};
        rom[10'h040] = {4'd5, 8'd3};
        rom[10'h041] = {4'd0, 8'd2};
        rom[10'h042] = {4'd7, 8'd1};
        rom[10'h043] = {4'd0, 8'd0};

        // Scenario 1: single play-through, song_sel wiggled while busy, pause in FETCH and play in PLAY ignored
        add(1,0,0,0,1, 1, 0,0,0,0, 0, 1,10'h000);
        add(0,1,0,0,0, 2, 0,0,1,0, 1, 1,10'h040);
        add(1,0,0,0,0,12, 5,1,1,0, 1, 1,10'h040);
        add(0,0,0,0,0,10, 0,0,1,0, 1, 1,10'h041);
        add(0,0,0,0,0, 8, 0,0,1,0, 1, 1,10'h041);
        add(0,0,0,0,0,10, 0,0,1,0, 1, 1,10'h042);
        add(0,0,0,0,0, 4, 7,1,1,0, 1, 1,10'h042);
        add(0,0,0,0,0,10, 0,0,1,0, 1, 1,10'h043);
        add(0,0,0,0,1, 1, 0,0,0,1, 1, 1,10'h043);
        add(0,0,0,0,1, 3, 0,0,0,0, 1, 0,10'h000);
        // Scenario 2: looping returns to {1,0} without song_done, then stop in GAP
        add(1,0,0,1,1, 1, 0,0,0,0, 1, 0,10'h000);
        add(0,0,0,1,1, 2, 0,0,1,0, 1, 1,10'h040);
        add(0,0,0,1,1,12, 5,1,1,0, 1, 1,10'h040);
        add(0,0,0,1,1,10, 0,0,1,0, 1, 1,10'h041);
        add(0,0,0,1,1, 8, 0,0,1,0, 1, 1,10'h041);
        add(0,0,0,1,1,10, 0,0,1,0, 1, 1,10'h042);
        add(0,0,0,1,1, 4, 7,1,1,0, 1, 1,10'h042);
        add(0,0,0,1,1,10, 0,0,1,0, 1, 1,10'h043);
        add(0,0,0,1,1, 2, 0,0,1,0, 1, 1,10'h040);
        add(0,0,0,1,1,12, 5,1,1,0, 1, 1,10'h040);
        add(0,0,1,1,1, 1, 0,0,1,0, 1, 1,10'h041);
        add(0,0,0,0,1, 2, 0,0,0,0, 1, 0,10'h000);
        // Scenario 3: pause at 6th cycle of note 5, hold 20, resume for exactly 6 cycles
        add(1,0,0,0,1, 1, 0,0,0,0, 1, 0,10'h000);
        add(0,0,0,0,1, 2, 0,0,1,0, 1, 1,10'h040);
        add(0,0,0,0,1, 5, 5,1,1,0, 1, 1,10'h040);
        add(0,1,0,0,1, 1, 5,1,1,0, 1, 1,10'h040);
        add(0,0,0,0,1,20, 0,0,1,0, 1, 1,10'h040);
        add(1,0,0,0,1, 1, 0,0,1,0, 1, 1,10'h040);
        add(0,0,0,0,1, 6, 5,1,1,0, 1, 1,10'h040);
        add(0,0,0,0,1, 1, 0,0,1,0, 1, 1,10'h041);
        add(0,0,1,0,1, 1, 0,0,1,0, 1, 1,10'h041);
        add(0,0,0,0,1, 2, 0,0,0,0, 1, 0,10'h000);
        // Scenario 4: stop+pause+play in PLAY, invalid song, pause in IDLE
        add(1,0,0,0,1, 1, 0,0,0,0, 1, 0,10'h000);
        add(0,0,0,0,1, 2, 0,0,1,0, 1, 1,10'h040);
        add(0,0,0,0,1, 3, 5,1,1,0, 1, 1,10'h040);
        add(1,1,1,0,1, 1, 5,1,1,0, 1, 1,10'h040);
        add(0,0,0,0,1, 3, 0,0,0,0, 1, 0,10'h000);
        add(1,0,0,0,2, 1, 0,0,0,0, 1, 0,10'h000);
        add(0,0,0,0,2, 3, 0,0,0,0, 1, 0,10'h000);
        add(0,1,0,0,0, 1, 0,0,0,0, 1, 0,10'h000);
        add(0,0,0,0,0, 2, 0,0,0,0, 1, 0,10'h000);

        reset = 1'b1; play = 0; pause = 0; stop = 0; loop_en = 0; song_sel = 4'd0;
        repeat (3) @(negedge clk);
        chk("rst_note", 32'(note_out), 0);
        chk("rst_valid", 32'(note_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(song_done), 0);
        chk("rst_song", 32'(current_song), 0);
        chk("rst_addr", 32'(rom_addr), 0);
        reset = 1'b0;

        for (int r = 0; r < vq.size(); r++) begin
            for (int c = 0; c < vq[r].n; c++) begin
                @(negedge clk);
                play     = (c == 0) ? vq[r].play  : 1'b0;
                pause    = (c == 0) ? vq[r].pause : 1'b0;
                stop     = (c == 0) ? vq[r].stop  : 1'b0;
                loop_en  = vq[r].loop_en;
                song_sel = vq[r].sel;
                chk($sformatf("v%0d.%0d note", r, c), 32'(note_out), 32'(vq[r].note));
                chk($sformatf("v%0d.%0d valid", r, c), 32'(note_valid), 32'(vq[r].valid));
                chk($sformatf("v%0d.%0d busy", r, c), 32'(busy), 32'(vq[r].busy));
                chk($sformatf("v%0d.%0d done", r, c), 32'(song_done), 32'(vq[r].done));
                chk($sformatf("v%0d.%0d song", r, c), 32'(current_song), 32'(vq[r].song));
                if (vq[r].chk_addr)
                    chk($sformatf("v%0d.%0d addr", r, c), 32'(rom_addr), 32'(vq[r].addr));
            end
        end

        // 64 entries of dur 1, no marker: end handling after idx 63
        @(negedge clk);
        play = 1; pause = 0; stop = 0; loop_en = 0; song_sel = 4'd0;
        done_at = -1; valid_cnt = 0; saw_last = 0;
        for (int k = 1; k <= 1000 && done_at < 0; k++) begin
            @(negedge clk);
            play = 0;
            if (note_valid) valid_cnt++;
            if (note_valid && rom_addr == 10'h03F) saw_last = 1;
            if (song_done) done_at = k;
        end
        chk("wrap_done_cycle", 32'(done_at), 889);
        chk("wrap_valid_cycles", 32'(valid_cnt), 256);
        chk("wrap_last_entry", 32'(saw_last), 1);
        chk("wrap_busy", 32'(busy), 0);
        @(negedge clk);
        chk("wrap_done_pulse", 32'(song_done), 0);

        // Reset mid-note
        play = 1; song_sel = 4'd1;
        @(negedge clk);
        play = 0;
        repeat (4) @(negedge clk);
        chk("midrst_pre_valid", 32'(note_valid), 1);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_note", 32'(note_out), 0);
        chk("midrst_valid", 32'(note_valid), 0);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_done", 32'(song_done), 0);
        chk("midrst_song", 32'(current_song), 0);
        chk("midrst_addr", 32'(rom_addr), 0);
        reset = 1'b0;
        @(negedge clk);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
